// File: rtl/kbd_event_decoder.sv
// PS/2 scancode to key-event decoder with a show-ahead event FIFO for the cpu MMIO port.
// Optional KBD_ASCII_EN adds a combinational US-layout ASCII lookup of the head event.
module kbd_event_decoder #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               ps2_data,
   input  logic                     ps2_ready,
   input  logic                     ps2_overflow,
   output logic                     ps2_rdn,
   input  logic                     kev_rd,
   output logic                     kev_valid,
   output logic [15:0]              kev_data,
   output logic [7:0]               kev_ascii,
   output logic                     kev_ovf,
   input  logic                     ovf_clr,
   output logic [$clog2(DEPTH):0]   kev_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_E0   = 2'd1;
   localparam logic [1:0] S_F0   = 2'd2;
   localparam logic [1:0] S_E0F0 = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic          byte_vld_q, byte_vld_d;
   logic          rdn_q, rdn_d;
   logic          lshift_q, lshift_d;
   logic          rshift_q, rshift_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];

   logic          capture;
   logic          push;
   logic          do_push;
   logic          pop;
   logic          brk;
   logic          ext;
   logic [15:0]   ev;

   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      push       = 1'b0;
      brk        = 1'b0;
      ext        = 1'b0;
      ev         = 16'h0000;

      // Room counts the byte still in flight so a capture never outruns the FIFO.
      capture    = ps2_ready & rdn_q & ((count_q + {{AW{1'b0}}, byte_vld_q}) < DEPTH_C);
      rdn_d      = ~capture;
      byte_vld_d = capture;
      if (capture) begin
         byte_d = ps2_data;
      end

      ovf_d = (ovf_q & ~ovf_clr) | ps2_overflow;

      if (byte_vld_q) begin
         if (byte_q == 8'h00 || byte_q == 8'hFF) begin
            ovf_d   = 1'b1;
            state_d = S_IDLE;
         end else if (byte_q == 8'hE0) begin
            case (state_q)
               S_IDLE:  state_d = S_E0;
               S_E0:    state_d = S_E0;
               default: state_d = S_E0F0;
            endcase
         end else if (byte_q == 8'hF0) begin
            case (state_q)
               S_IDLE:  state_d = S_F0;
               S_F0:    state_d = S_F0;
               default: state_d = S_E0F0;
            endcase
         end else begin
            brk = (state_q == S_F0) || (state_q == S_E0F0);
            ext = (state_q == S_E0) || (state_q == S_E0F0);
            if (!ext && byte_q == 8'h12) begin
               lshift_d = ~brk;
            end
            if (!ext && byte_q == 8'h59) begin
               rshift_d = ~brk;
            end
            push    = 1'b1;
            ev      = {5'b00000, lshift_d | rshift_d, ext, brk, byte_q};
            state_d = S_IDLE;
         end
      end

      pop     = kev_rd & (count_q != '0);
      do_push = push & ((count_q != DEPTH_C) | pop);

      if (do_push) begin
         mem_d[wr_ptr_q] = ev;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         byte_q     <= 8'h00;
         byte_vld_q <= 1'b0;
         rdn_q      <= 1'b1;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         byte_vld_q <= byte_vld_d;
         rdn_q      <= rdn_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: kev_data is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ps2_rdn   = rdn_q;
   assign kev_valid = (count_q != '0);
   assign kev_data  = kev_valid ? mem_q[rd_ptr_q] : 16'h0000;
   assign kev_ovf   = ovf_q;
   assign kev_count = count_q;

`ifdef KBD_ASCII_EN
   function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic shift);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
         8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
         8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
         8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
         8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
         8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
         8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      if (a >= 8'h41 && a <= 8'h5A && !shift) begin
         a = a | 8'h20;
      end
      return a;
   endfunction

   always_comb begin
      kev_ascii = 8'h00;
      if (kev_valid && !kev_data[8] && !kev_data[9]) begin
         kev_ascii = ascii_of(kev_data[7:0], kev_data[10]);
      end
   end
`else
   assign kev_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Self-checking bench for kbd_event_decoder: a queue models ps2_kbd, a vector table drives
// single bytes through the decoder, and hand-written sequences cover FIFO-full, overflow and reset.
module tb_kbd_event_decoder;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef KBD_ASCII_EN
   localparam bit ASCII_EN = 1'b1;
`else
   localparam bit ASCII_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    ps2_data;
   logic          ps2_ready;
   logic          ps2_overflow;
   logic          ps2_rdn;
   logic          kev_rd;
   logic          kev_valid;
   logic [15:0]   kev_data;
   logic [7:0]    kev_ascii;
   logic          kev_ovf;
   logic          ovf_clr;
   logic [CW-1:0] kev_count;

   logic [7:0]    ps2q [$];
   int            nCompared = 0;
   int            nMismatched = 0;

   typedef struct {
      logic [7:0]  b;
      logic        hasEv;
      logic [15:0] ev;
      logic [7:0]  asc;
   } vec_t;

   vec_t          vecs [32];
   logic [7:0]    fillCodes [DEPTH+3];

   always #5 clk = ~clk;

   kbd_event_decoder #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2_data     (ps2_data),
      .ps2_ready    (ps2_ready),
      .ps2_overflow (ps2_overflow),
      .ps2_rdn      (ps2_rdn),
      .kev_rd       (kev_rd),
      .kev_valid    (kev_valid),
      .kev_data     (kev_data),
      .kev_ascii    (kev_ascii),
      .kev_ovf      (kev_ovf),
      .ovf_clr      (ovf_clr),
      .kev_count    (kev_count)
   );

   // ps2_kbd model: pops its head on the edge that ends a low ps2_rdn cycle.
   always @(posedge clk) begin
      if (!ps2_rdn && ps2q.size() > 0) begin
         ps2q.delete(0);
      end
   end

   always @(negedge clk) begin
      #2;
      ps2_ready = (ps2q.size() != 0);
      ps2_data  = (ps2q.size() != 0) ? ps2q[0] : 8'h00;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      ps2q.push_back(b);
   endtask

   task automatic popEvent();
      kev_rd = 1'b1;
      @(negedge clk);
      kev_rd = 1'b0;
   endtask

   task automatic doReset();
      rst          = 1'b1;
      kev_rd       = 1'b0;
      ovf_clr      = 1'b0;
      ps2_overflow = 1'b0;
      ps2q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int rdnLows;

      vecs[0]  = '{8'h1C, 1'b1, 16'h001C, 8'h61};
      vecs[1]  = '{8'hF0, 1'b0, 16'h0000, 8'h00};
      vecs[2]  = '{8'h1C, 1'b1, 16'h011C, 8'h00};
      vecs[3]  = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[4]  = '{8'hF0, 1'b0, 16'h0000, 8'h00};
      vecs[5]  = '{8'h75, 1'b1, 16'h0375, 8'h00};
      vecs[6]  = '{8'h12, 1'b1, 16'h0412, 8'h00};
      vecs[7]  = '{8'h1C, 1'b1, 16'h041C, 8'h41};
      vecs[8]  = '{8'hF0, 1'b0, 16'h0000, 8'h00};
      vecs[9]  = '{8'h12, 1'b1, 16'h0112, 8'h00};
      vecs[10] = '{8'h1C, 1'b1, 16'h001C, 8'h61};
      vecs[11] = '{8'h59, 1'b1, 16'h0459, 8'h00};
      vecs[12] = '{8'h16, 1'b1, 16'h0416, 8'h31};
      vecs[13] = '{8'h1C, 1'b1, 16'h041C, 8'h41};
      vecs[14] = '{8'hF0, 1'b0, 16'h0000, 8'h00};
      vecs[15] = '{8'h59, 1'b1, 16'h0159, 8'h00};
      vecs[16] = '{8'h29, 1'b1, 16'h0029, 8'h20};
      vecs[17] = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[18] = '{8'h12, 1'b1, 16'h0212, 8'h00};
      vecs[19] = '{8'h1C, 1'b1, 16'h001C, 8'h61};
      vecs[20] = '{8'h5A, 1'b1, 16'h005A, 8'h0D};
      vecs[21] = '{8'h66, 1'b1, 16'h0066, 8'h08};
      vecs[22] = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[23] = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[24] = '{8'h1C, 1'b1, 16'h021C, 8'h00};
      vecs[25] = '{8'hF0, 1'b0, 16'h0000, 8'h00};
      vecs[26] = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[27] = '{8'h1C, 1'b1, 16'h031C, 8'h00};
      vecs[28] = '{8'hE0, 1'b0, 16'h0000, 8'h00};
      vecs[29] = '{8'h00, 1'b0, 16'h0000, 8'h00};
      vecs[30] = '{8'h1C, 1'b1, 16'h001C, 8'h61};
      vecs[31] = '{8'h45, 1'b1, 16'h0045, 8'h30};

      fillCodes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
                    8'h3C, 8'h43, 8'h44, 8'h4D, 8'h1B};

      rst          = 1'b1;
      ps2_ready    = 1'b0;
      ps2_data     = 8'h00;
      ps2_overflow = 1'b0;
      kev_rd       = 1'b0;
      ovf_clr      = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_rdn",   16'(ps2_rdn),   16'h0001);
      checkOutput("rst_valid", 16'(kev_valid), 16'h0000);
      checkOutput("rst_data",  kev_data,       16'h0000);
      checkOutput("rst_ascii", 16'(kev_ascii), 16'h0000);
      checkOutput("rst_ovf",   16'(kev_ovf),   16'h0000);
      checkOutput("rst_count", 16'(kev_count), 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single byte timing");
      applyStimulus(8'h1C);
      @(negedge clk);
      checkOutput("t1_rdn_low",     16'(ps2_rdn),   16'h0000);
      checkOutput("t1_valid_early", 16'(kev_valid), 16'h0000);
      @(negedge clk);
      checkOutput("t1_rdn_high",    16'(ps2_rdn),   16'h0001);
      checkOutput("t1_valid",       16'(kev_valid), 16'h0001);
      checkOutput("t1_data",        kev_data,       16'h001C);
      checkOutput("t1_count",       16'(kev_count), 16'h0001);
      @(negedge clk);
      checkOutput("t1_rdn_stays",   16'(ps2_rdn),   16'h0001);
      popEvent();
      checkOutput("t1_empty",       16'(kev_valid), 16'h0000);
      checkOutput("t1_data_empty",  kev_data,       16'h0000);

      $display("[TB] vector table");
      doReset();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(vecs[i].b);
         repeat (2) @(negedge clk);
         checkOutput($sformatf("vec%0d_rdn", i), 16'(ps2_rdn), 16'h0001);
         if (vecs[i].hasEv) begin
            checkOutput($sformatf("vec%0d_valid", i), 16'(kev_valid), 16'h0001);
            checkOutput($sformatf("vec%0d_data", i), kev_data, vecs[i].ev);
            checkOutput($sformatf("vec%0d_ascii", i), 16'(kev_ascii),
                        ASCII_EN ? 16'(vecs[i].asc) : 16'h0000);
            popEvent();
         end else begin
            checkOutput($sformatf("vec%0d_noev", i), 16'(kev_count), 16'h0000);
         end
      end

      $display("[TB] fifo full and drain");
      doReset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         applyStimulus(fillCodes[i]);
      end
      repeat (40) @(negedge clk);
      checkOutput("t4_count_sat", 16'(kev_count),   16'(DEPTH));
      checkOutput("t4_left_in_q", 16'(ps2q.size()), 16'h0003);
      rdnLows = 0;
      for (int i = 0; i < 5; i++) begin
         if (!ps2_rdn) rdnLows++;
         @(negedge clk);
      end
      checkOutput("t4_rdn_held", 16'(rdnLows), 16'h0000);
      for (int i = 0; i < DEPTH + 3; i++) begin
         checkOutput($sformatf("t4_pop%0d_valid", i), 16'(kev_valid), 16'h0001);
         checkOutput($sformatf("t4_pop%0d_data", i), kev_data, {8'h00, fillCodes[i]});
         popEvent();
         repeat (2) @(negedge clk);
      end
      checkOutput("t4_final_count", 16'(kev_count), 16'h0000);
      checkOutput("t4_final_valid", 16'(kev_valid), 16'h0000);
      kev_rd = 1'b1;
      @(negedge clk);
      kev_rd = 1'b0;
      checkOutput("t4_rd_empty",    16'(kev_count), 16'h0000);

      $display("[TB] overflow flag");
      doReset();
      applyStimulus(8'hFF);
      repeat (2) @(negedge clk);
      checkOutput("t5_err_noev", 16'(kev_valid), 16'h0000);
      checkOutput("t5_err_ovf",  16'(kev_ovf),   16'h0001);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checkOutput("t5_clr",      16'(kev_ovf),   16'h0000);
      ps2_overflow = 1'b1;
      @(negedge clk);
      ps2_overflow = 1'b0;
      checkOutput("t5_ps2ovf",   16'(kev_ovf),   16'h0001);
      ps2_overflow = 1'b1;
      ovf_clr      = 1'b1;
      @(negedge clk);
      ps2_overflow = 1'b0;
      ovf_clr      = 1'b0;
      checkOutput("t5_set_wins", 16'(kev_ovf),   16'h0001);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checkOutput("t5_clr2",     16'(kev_ovf),   16'h0000);
      applyStimulus(8'h1C);
      repeat (2) @(negedge clk);
      checkOutput("t5_after_err", kev_data,      16'h001C);

      $display("[TB] reset mid-frame");
      doReset();
      applyStimulus(8'h1C);
      applyStimulus(8'h1D);
      applyStimulus(8'h24);
      repeat (8) @(negedge clk);
      checkOutput("t6_held", 16'(kev_count), 16'h0003);
      applyStimulus(8'hE0);
      applyStimulus(8'hE0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6_count", 16'(kev_count), 16'h0000);
      checkOutput("t6_rdn",   16'(ps2_rdn),   16'h0001);
      checkOutput("t6_valid", 16'(kev_valid), 16'h0000);
      applyStimulus(8'h1C);
      repeat (2) @(negedge clk);
      checkOutput("t6_fsm_idle", kev_data,    16'h001C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
